// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Bus layouts match the EX->MEM and MEM->WB pipeline register packing.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 81;
   localparam int MEM_TO_WB_WD = 70;
   localparam int MEM_TO_ID_WD = 38;
   localparam int HILO_WD      = 65;
   localparam int STALL_W      = 6;

   localparam int STALL_EX_MEM = 3;
   localparam int STALL_MEM_WB = 4;
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // load_op is one-hot {lb,lbu,lh,lhu,lw}
   localparam int LD_LB  = 4;
   localparam int LD_LBU = 3;
   localparam int LD_LH  = 2;
   localparam int LD_LHU = 1;
   localparam int LD_LW  = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
      logic [4:0]  load_op;
   } ex_to_mem_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } mem_to_wb_t;

   function automatic logic is_load(input ex_to_mem_t b);
      return b.ram_en & (|b.load_op);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/SRAM-facing inputs and WB/ID-facing outputs of the MEM stage.
// master is the surrounding pipeline, slave is mem_stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [STALL_W-1:0]      stall;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [HILO_WD-1:0]      ex_to_mem_hilo;
   logic [31:0]             data_sram_rdata;
   logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
   logic [HILO_WD-1:0]      mem_to_wb_hilo;
   logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

   modport master (
      output stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata,
      input  mem_to_wb_bus, mem_to_wb_hilo, mem_to_id_bus
   );

   modport slave (
      input  stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata,
      output mem_to_wb_bus, mem_to_wb_hilo, mem_to_id_bus
   );
endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a loaded word and sign/zero-extends it.
// Purely combinational; misaligned half/word offsets are not checked here.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] data_src_i,
   input  logic [1:0]  off_i,
   input  logic [4:0]  load_op_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = data_src_i[{off_i, 3'b000} +: 8];
   assign half_v = data_src_i[{off_i[1], 4'b0000} +: 16];

   always_comb begin
      result_o = data_src_i;
      if (load_op_i[LD_LB])       result_o = {{24{byte_v[7]}}, byte_v};
      else if (load_op_i[LD_LBU]) result_o = {24'h0, byte_v};
      else if (load_op_i[LD_LH])  result_o = {{16{half_v[15]}}, half_v};
      else if (load_op_i[LD_LHU]) result_o = {16'h0, half_v};
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load-data hold FSM and alignment, WB and ID forwarding buses.
// One cycle from EX to outputs; SRAM data is captured on its only valid cycle so it survives WB stalls.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  bus
);

   typedef enum logic [1:0] {LD_IDLE, LD_FRESH, LD_HELD} ld_state_e;

   ex_to_mem_t         ex_in;
   ex_to_mem_t         bus_q;
   logic [HILO_WD-1:0] hilo_q;
   ld_state_e          state_q;
   logic [31:0]        rdata_hold_q;

   logic [31:0] data_src;
   logic [31:0] aligned;
   logic [31:0] rf_wdata;
   mem_to_wb_t  wb;

   assign ex_in = ex_to_mem_t'(bus.ex_to_mem_bus);

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus_q        <= '0;
         hilo_q       <= '0;
         state_q      <= LD_IDLE;
         rdata_hold_q <= '0;
      end else begin
         if (bus.stall[STALL_EX_MEM] && !bus.stall[STALL_MEM_WB]) begin
            bus_q   <= '0;
            hilo_q  <= '0;
            state_q <= LD_IDLE;
         end else if (!bus.stall[STALL_EX_MEM]) begin
            bus_q   <= ex_in;
            hilo_q  <= bus.ex_to_mem_hilo;
            state_q <= is_load(ex_in) ? LD_FRESH : LD_IDLE;
         end else if (state_q == LD_FRESH) begin
            // Holding here implies stall[4]=1, so the load stays in MEM.
            state_q <= LD_HELD;
         end
         if (state_q == LD_FRESH)
            rdata_hold_q <= bus.data_sram_rdata;
      end
   end

   assign data_src = (state_q == LD_HELD) ? rdata_hold_q : bus.data_sram_rdata;

   mem_stage_load_align u_align (
      .data_src_i (data_src),
      .off_i      (bus_q.ex_result[1:0]),
      .load_op_i  (bus_q.load_op),
      .result_o   (aligned)
   );

   // A store never writes the register file with memory data.
   assign rf_wdata = (bus_q.sel_rf_res && (bus_q.ram_wen == 4'h0)) ? aligned : bus_q.ex_result;

   always_comb begin
      wb.pc       = bus_q.pc;
      wb.rf_we    = bus_q.rf_we;
      wb.rf_waddr = bus_q.rf_waddr;
      wb.rf_wdata = rf_wdata;
   end

   assign bus.mem_to_wb_bus  = wb;
   assign bus.mem_to_wb_hilo = hilo_q;
   assign bus.mem_to_id_bus  = {wb.rf_we, wb.rf_waddr, wb.rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboarded loads, stalls, bubbles and reset.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_if bus_if ();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   int checks   = 0;
   int failures = 0;
   logic [MEM_TO_WB_WD-1:0] exp_q[$];

   function automatic logic [80:0] mk(input logic [31:0] pc, input logic ram_en,
                                      input logic [3:0] wen, input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [31:0] res,
                                      input logic [4:0] lop);
      return {pc, ram_en, wen, sel, we, wa, res, lop};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [95:0] r;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         r = {$urandom(), $urandom(), $urandom()};
         bus_if.ex_to_mem_bus   = r[80:0];
         bus_if.ex_to_mem_hilo  = r[95:31];
         bus_if.stall           = r[5:0];
         bus_if.data_sram_rdata = $urandom();
         tick();
         checks++;
         if (bus_if.mem_to_wb_bus !== '0) begin
            failures++;
            $display("FAIL reset_wb[%0d]: got %h expected 0", i, bus_if.mem_to_wb_bus);
         end
         checks++;
         if (bus_if.mem_to_wb_hilo !== '0) begin
            failures++;
            $display("FAIL reset_hilo[%0d]: got %h expected 0", i, bus_if.mem_to_wb_hilo);
         end
         checks++;
         if (bus_if.mem_to_id_bus !== '0) begin
            failures++;
            $display("FAIL reset_id[%0d]: got %h expected 0", i, bus_if.mem_to_id_bus);
         end
      end
      bus_if.ex_to_mem_bus   = '0;
      bus_if.ex_to_mem_hilo  = '0;
      bus_if.stall           = '0;
      bus_if.data_sram_rdata = '0;
      rst = 1'b1;
      tick();
   endtask

   // One unstalled load through MEM, checked against the scoreboard.
   task automatic run_one(input string name, input logic [31:0] pc, input logic [4:0] lop,
                          input logic [1:0] off, input logic [31:0] rdata,
                          input logic [31:0] exp_data);
      logic [MEM_TO_WB_WD-1:0] exp_w;
      logic [HILO_WD-1:0]      exp_h;
      exp_h = {1'b1, pc, ~pc};
      exp_q.push_back({pc, 1'b1, 5'd7, exp_data});
      bus_if.stall          = '0;
      bus_if.ex_to_mem_bus  = mk(pc, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, {30'h400, off}, lop);
      bus_if.ex_to_mem_hilo = exp_h;
      tick();
      bus_if.ex_to_mem_bus   = '0;
      bus_if.ex_to_mem_hilo  = '0;
      bus_if.data_sram_rdata = rdata;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s_wb: scoreboard empty, got %h", name, bus_if.mem_to_wb_bus);
      end else begin
         exp_w = exp_q.pop_front();
         if (bus_if.mem_to_wb_bus !== exp_w) begin
            failures++;
            $display("FAIL %s_wb: got %h expected %h", name, bus_if.mem_to_wb_bus, exp_w);
         end
         checks++;
         if (bus_if.mem_to_id_bus !== exp_w[37:0]) begin
            failures++;
            $display("FAIL %s_id: got %h expected %h", name, bus_if.mem_to_id_bus, exp_w[37:0]);
         end
      end
      checks++;
      if (bus_if.mem_to_wb_hilo !== exp_h) begin
         failures++;
         $display("FAIL %s_hilo: got %h expected %h", name, bus_if.mem_to_wb_hilo, exp_h);
      end
   endtask

   task automatic test_load_align();
      run_one("lw",      32'h100, 5'b00001, 2'd0, 32'h8899AABB, 32'h8899AABB);
      run_one("lb_off1", 32'h104, 5'b10000, 2'd1, 32'h0000F000, 32'hFFFFFFF0);
      run_one("lbu_off1",32'h108, 5'b01000, 2'd1, 32'h0000F000, 32'h000000F0);
      run_one("lh_off2", 32'h10C, 5'b00100, 2'd2, 32'h80000000, 32'hFFFF8000);
      run_one("lhu_off2",32'h110, 5'b00010, 2'd2, 32'h80000000, 32'h00008000);
      run_one("lb_off3", 32'h114, 5'b10000, 2'd3, 32'h80000000, 32'hFFFFFF80);
      run_one("lhu_off0",32'h118, 5'b00010, 2'd0, 32'h1234ABCD, 32'h0000ABCD);
   endtask

   task automatic test_held_stall();
      logic [MEM_TO_WB_WD-1:0] exp_w;
      exp_q.push_back({32'h300, 1'b1, 5'd9, 32'h12345678});
      bus_if.stall         = '0;
      bus_if.ex_to_mem_bus = mk(32'h300, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h2000, 5'b00001);
      tick();
      bus_if.ex_to_mem_bus   = '0;
      bus_if.stall           = 6'b011000;
      bus_if.data_sram_rdata = 32'h12345678;
      #1;
      checks++;
      if (bus_if.mem_to_wb_bus[31:0] !== 32'h12345678) begin
         failures++;
         $display("FAIL held_fresh: got %h expected 12345678", bus_if.mem_to_wb_bus[31:0]);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         bus_if.data_sram_rdata = 32'hDEADBEEF;
         #1;
         checks++;
         if (bus_if.mem_to_wb_bus[31:0] !== 32'h12345678) begin
            failures++;
            $display("FAIL held_%0d: got %h expected 12345678", i, bus_if.mem_to_wb_bus[31:0]);
         end
      end
      bus_if.stall = '0;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL held_leave: scoreboard empty, got %h", bus_if.mem_to_wb_bus);
      end else begin
         exp_w = exp_q.pop_front();
         if (bus_if.mem_to_wb_bus !== exp_w) begin
            failures++;
            $display("FAIL held_leave: got %h expected %h", bus_if.mem_to_wb_bus, exp_w);
         end
      end
      tick();
   endtask

   task automatic test_bubble();
      logic [MEM_TO_WB_WD-1:0] exp_w;
      bus_if.stall          = '0;
      bus_if.ex_to_mem_bus  = mk(32'h400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'hCAFE0001, 5'b0);
      bus_if.ex_to_mem_hilo = {1'b1, 32'h1, 32'h2};
      tick();
      exp_w = {32'h400, 1'b1, 5'd3, 32'hCAFE0001};
      checks++;
      if (bus_if.mem_to_wb_bus !== exp_w) begin
         failures++;
         $display("FAIL alu_pass: got %h expected %h", bus_if.mem_to_wb_bus, exp_w);
      end
      checks++;
      if (bus_if.mem_to_wb_hilo !== {1'b1, 32'h1, 32'h2}) begin
         failures++;
         $display("FAIL alu_hilo: got %h expected %h", bus_if.mem_to_wb_hilo, {1'b1, 32'h1, 32'h2});
      end
      bus_if.ex_to_mem_bus  = mk(32'h404, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'hABCD0002, 5'b0);
      bus_if.ex_to_mem_hilo = '0;
      tick();
      bus_if.data_sram_rdata = 32'h5A5A5A5A;
      #1;
      exp_w = {32'h404, 1'b0, 5'd0, 32'hABCD0002};
      checks++;
      if (bus_if.mem_to_wb_bus !== exp_w) begin
         failures++;
         $display("FAIL store_pass: got %h expected %h", bus_if.mem_to_wb_bus, exp_w);
      end
      bus_if.ex_to_mem_bus  = mk(32'h408, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h77, 5'b0);
      bus_if.ex_to_mem_hilo = {1'b1, 32'h3, 32'h4};
      bus_if.stall          = 6'b001000;
      tick();
      checks++;
      if (bus_if.mem_to_wb_bus !== '0) begin
         failures++;
         $display("FAIL bubble_wb: got %h expected 0", bus_if.mem_to_wb_bus);
      end
      checks++;
      if (bus_if.mem_to_wb_hilo !== '0) begin
         failures++;
         $display("FAIL bubble_hilo: got %h expected 0", bus_if.mem_to_wb_hilo);
      end
      checks++;
      if (bus_if.mem_to_id_bus !== '0) begin
         failures++;
         $display("FAIL bubble_id: got %h expected 0", bus_if.mem_to_id_bus);
      end
      bus_if.stall          = '0;
      bus_if.ex_to_mem_bus  = '0;
      bus_if.ex_to_mem_hilo = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [MEM_TO_WB_WD-1:0] exp_w;
      exp_q.push_back({32'h500, 1'b1, 5'd10, 32'h11111111});
      exp_q.push_back({32'h504, 1'b1, 5'd11, 32'h22222222});
      bus_if.stall         = '0;
      bus_if.ex_to_mem_bus = mk(32'h500, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h3000, 5'b00001);
      tick();
      for (int i = 0; i < 2; i++) begin
         bus_if.ex_to_mem_bus = (i == 0) ?
            mk(32'h504, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h3004, 5'b00001) : '0;
         bus_if.data_sram_rdata = (i == 0) ? 32'h11111111 : 32'h22222222;
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL b2b_%0d: scoreboard empty, got %h", i, bus_if.mem_to_wb_bus);
         end else begin
            exp_w = exp_q.pop_front();
            if (bus_if.mem_to_wb_bus !== exp_w) begin
               failures++;
               $display("FAIL b2b_%0d: got %h expected %h", i, bus_if.mem_to_wb_bus, exp_w);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_held();
      bus_if.stall         = '0;
      bus_if.ex_to_mem_bus = mk(32'h600, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h4000, 5'b00001);
      tick();
      bus_if.ex_to_mem_bus   = '0;
      bus_if.stall           = 6'b011000;
      bus_if.data_sram_rdata = 32'h33333333;
      tick();
      bus_if.data_sram_rdata = 32'h44444444;
      #1;
      checks++;
      if (bus_if.mem_to_wb_bus[31:0] !== 32'h33333333) begin
         failures++;
         $display("FAIL rst_held_data: got %h expected 33333333", bus_if.mem_to_wb_bus[31:0]);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus_if.mem_to_wb_bus !== '0 || bus_if.mem_to_id_bus !== '0 || bus_if.mem_to_wb_hilo !== '0) begin
         failures++;
         $display("FAIL rst_mid_held: got wb=%h id=%h hilo=%h expected all 0",
                  bus_if.mem_to_wb_bus, bus_if.mem_to_id_bus, bus_if.mem_to_wb_hilo);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (bus_if.mem_to_wb_bus !== '0) begin
         failures++;
         $display("FAIL rst_release_hold: got %h expected 0", bus_if.mem_to_wb_bus);
      end
      bus_if.stall = '0;
      run_one("post_rst_lw", 32'h604, 5'b00001, 2'd0, 32'h55667788, 32'h55667788);
   endtask

   initial begin
      test_reset();
      test_load_align();
      test_held_stall();
      test_bubble();
      test_back_to_back();
      test_reset_mid_held();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
